// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: request/response handshakes and datapath hookup for fpu_issue_ctrl.
interface fpu_issue_ctrl_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op;
    logic [1:0]   req_db;
    logic [3:0]   req_rm;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [63:0]  rsp_data;
    logic [4:0]   rsp_flags;
    logic         busy;
    logic [63:0]  dp_fpa;
    logic [63:0]  dp_fpb;
    logic         dp_db;
    logic         dp_sub;
    logic         dp_fdiv;
    logic         dp_normal;
    logic [1:0]   dp_rm;
    logic [63:0]  dp_add_fp;
    logic [63:0]  dp_mul_fp;
    logic [4:0]   dp_add_ieee;
    logic [4:0]   dp_mul_ieee;
    modport slave (
        input  req_valid, req_op, req_db, req_rm, req_a, req_b, rsp_ready,
               dp_add_fp, dp_mul_fp, dp_add_ieee, dp_mul_ieee,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, busy,
               dp_fpa, dp_fpb, dp_db, dp_sub, dp_fdiv, dp_normal, dp_rm
    );
    modport master (
        output req_valid, req_op, req_db, req_rm, req_a, req_b, rsp_ready,
               dp_add_fp, dp_mul_fp, dp_add_ieee, dp_mul_ieee,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, busy,
               dp_fpa, dp_fpb, dp_db, dp_sub, dp_fdiv, dp_normal, dp_rm
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: round-robin issue and multicycle sequencing for the shared FPU datapath.
// FPU_ISSUE_CTRL_STICKY_FLAGS_EN adds accumulated IEEE flags (flags_sticky) with a clear.
module fpu_issue_ctrl #(
    parameter int ADD_WAIT = 2,
    parameter int MUL_WAIT = 3,
    parameter int DIV_WAIT = 6
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FPU_ISSUE_CTRL_STICKY_FLAGS_EN
    input  logic       flags_clr,
    output logic [4:0] flags_sticky,
`endif
    fpu_issue_ctrl_if.slave bus
);
    localparam int MAXW = (ADD_WAIT > MUL_WAIT) ? ((ADD_WAIT > DIV_WAIT) ? ADD_WAIT : DIV_WAIT)
                                                : ((MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT);
    localparam int CW = (MAXW > 8) ? $clog2(MAXW) : 3;
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t        r_state, w_next;
    logic          r_last_id, r_mul, r_id;
    logic [CW-1:0] r_cnt, w_load;
    logic [1:0]    w_grant, w_op;
    logic          w_gid, w_hs, w_cap;
    logic          r_rsp_valid, r_rsp_id;
    logic [63:0]   r_rsp_data, r_fpa, r_fpb;
    logic [4:0]    r_rsp_flags, w_flags;
    logic          r_db, r_sub, r_fdiv;
    logic [1:0]    r_rm;
    always_comb begin
        w_grant = (r_state != IDLE) ? 2'b00
                : (bus.req_valid == 2'b11) ? (r_last_id ? 2'b01 : 2'b10) : bus.req_valid;
        w_gid   = w_grant[1];
        w_hs    = |w_grant;
        w_op    = w_gid ? bus.req_op[3:2] : bus.req_op[1:0];
        w_load  = w_op[1] ? (w_op[0] ? CW'(DIV_WAIT - 1) : CW'(MUL_WAIT - 1)) : CW'(ADD_WAIT - 1);
        w_cap   = (r_state == EXEC) && (r_cnt == '0);
        w_flags = r_mul ? bus.dp_mul_ieee : bus.dp_add_ieee;
        w_next  = w_hs ? EXEC
                : w_cap ? HOLD
                : (r_state == HOLD && bus.rsp_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_id   <= 1'b1;
            r_mul       <= 1'b0;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_fpa       <= '0;
            r_fpb       <= '0;
            r_db        <= 1'b0;
            r_sub       <= 1'b0;
            r_fdiv      <= 1'b0;
            r_rm        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            // datapath operands change only on a handshake so the multicycle path stays stable
            if (w_hs) begin
                r_fpa     <= w_gid ? bus.req_a[127:64] : bus.req_a[63:0];
                r_fpb     <= w_gid ? bus.req_b[127:64] : bus.req_b[63:0];
                r_db      <= bus.req_db[w_gid];
                r_rm      <= w_gid ? bus.req_rm[3:2] : bus.req_rm[1:0];
                r_sub     <= (w_op == 2'b01);
                r_fdiv    <= (w_op == 2'b11);
                r_mul     <= w_op[1];
                r_id      <= w_gid;
                r_last_id <= w_gid;
                r_cnt     <= w_load;
            end else if (r_state == EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_cap) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= r_mul ? bus.dp_mul_fp : bus.dp_add_fp;
                r_rsp_flags <= w_flags;
            end else if (r_state == HOLD && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end
`ifdef FPU_ISSUE_CTRL_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)         flags_sticky <= '0;
        else if (flags_clr) flags_sticky <= '0;
        else if (w_cap)     flags_sticky <= flags_sticky | w_flags;
`endif
    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dp_fpa    = r_fpa;
    assign bus.dp_fpb    = r_fpb;
    assign bus.dp_db     = r_db;
    assign bus.dp_sub    = r_sub;
    assign bus.dp_fdiv   = r_fdiv;
    assign bus.dp_normal = 1'b1;
    assign bus.dp_rm     = r_rm;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of arbitration, latency, backpressure, path select and reset.
// Define FPU_ISSUE_CTRL_STICKY_FLAGS_EN to also exercise the sticky flag register.
module tb_fpu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [63:0] noise = '0;
    int n_tot = 0, n_pass = 0, viol = 0;
    fpu_issue_ctrl_if bus();
`ifdef FPU_ISSUE_CTRL_STICKY_FLAGS_EN
    logic flags_clr = 1'b0;
    logic [4:0] flags_sticky;
    fpu_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .flags_clr(flags_clr), .flags_sticky(flags_sticky), .bus(bus));
`else
    fpu_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
    always #5 clk = ~clk;
    // datapath stand-in: add path sums, muldiv path xors; noise perturbs results while held
    assign bus.dp_add_fp   = (bus.dp_fpa + bus.dp_fpb) ^ noise;
    assign bus.dp_mul_fp   = (bus.dp_fpa ^ bus.dp_fpb) ^ noise;
    assign bus.dp_add_ieee = 5'b00001 ^ noise[4:0];
    assign bus.dp_mul_ieee = 5'b00100 ^ noise[4:0];
    always @(negedge clk)
        if (rst_n && bus.busy && bus.req_ready != 2'b00) viol++;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic issue(input int id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic db, input logic [1:0] rm);
        bus.req_op[id*2 +: 2] = op;
        bus.req_rm[id*2 +: 2] = rm;
        bus.req_db[id]        = db;
        bus.req_a[id*64 +: 64] = a;
        bus.req_b[id*64 +: 64] = b;
        bus.req_valid = (id == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("grant", 64'(bus.req_ready), 64'(bus.req_valid));
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
    endtask
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic to_idle;
        @(posedge clk);
        #1;
    endtask
    int lat, bad, ng, nr, gap;
    logic [1:0] grants [4];
    logic [1:0] ids [4];
    logic [63:0] datas [4];
    int gcyc [4];
    initial begin
        bus.req_valid = '0; bus.req_op = '0; bus.req_db = '0; bus.req_rm = '0;
        bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_dp_fpa", bus.dp_fpa, 64'd0);
        chk("rst_dp_normal", 64'(bus.dp_normal), 64'd1);
        rst_n = 1'b1;
        to_idle();
        issue(0, 2'b00, 64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 2'b00);
        wait_rsp(lat);
        chk("add_latency", 64'(lat), 64'd3);
        chk("add_id", 64'(bus.rsp_id), 64'd0);
        chk("add_data", bus.rsp_data, 64'h7FF0000000000000);
        chk("add_flags", 64'(bus.rsp_flags), 64'h01);
        chk("add_dp_db", 64'(bus.dp_db), 64'd1);
        to_idle();
        @(negedge clk);
        chk("add_idle_busy", 64'(bus.busy), 64'd0);
        chk("add_idle_valid", 64'(bus.rsp_valid), 64'd0);
        to_idle();
        issue(0, 2'b01, 64'h10, 64'h3, 1'b0, 2'b01);
        #3;
        chk("sub_dp_sub", 64'(bus.dp_sub), 64'd1);
        chk("sub_dp_fdiv", 64'(bus.dp_fdiv), 64'd0);
        chk("sub_dp_rm", 64'(bus.dp_rm), 64'd1);
        wait_rsp(lat);
        chk("sub_latency", 64'(lat), 64'd3);
        chk("sub_flags", 64'(bus.rsp_flags), 64'h01);
        to_idle();
        issue(1, 2'b10, 64'hF0F0, 64'h0FF0, 1'b0, 2'b10);
        #3;
        chk("mul_dp_sub", 64'(bus.dp_sub), 64'd0);
        chk("mul_dp_rm", 64'(bus.dp_rm), 64'd2);
        wait_rsp(lat);
        chk("mul_latency", 64'(lat), 64'd4);
        chk("mul_id", 64'(bus.rsp_id), 64'd1);
        chk("mul_data", bus.rsp_data, 64'hFF00);
        chk("mul_flags", 64'(bus.rsp_flags), 64'h04);
        to_idle();
        bus.rsp_ready = 1'b0;
        issue(1, 2'b11, 64'h55, 64'h0F, 1'b1, 2'b11);
        #3;
        chk("div_dp_fdiv", 64'(bus.dp_fdiv), 64'd1);
        wait_rsp(lat);
        chk("div_latency", 64'(lat), 64'd7);
        chk("div_data", bus.rsp_data, 64'h5A);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 noise = {$urandom, $urandom};
            bus.req_valid = 2'b11;
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h5A || bus.rsp_flags !== 5'b00100 || bus.rsp_id !== 1'b1)
                bad++;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        bus.req_valid = 2'b00;
        noise = '0;
        bus.rsp_ready = 1'b1;
        to_idle();
        @(negedge clk);
        chk("bp_release_busy", 64'(bus.busy), 64'd0);
        chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        to_idle();
        issue(0, 2'b10, 64'h1234, 64'h1, 1'b0, 2'b00);
        to_idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_dp_fpa", bus.dp_fpa, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("midrst_tie", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 2'b00;
        to_idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        to_idle();
        bus.req_op = 4'b0000;
        bus.req_a = {64'd2, 64'd1};
        bus.req_b = {64'd2, 64'd1};
        bus.req_valid = 2'b11;
        ng = 0; nr = 0;
        for (int c = 0; c < 60 && (ng < 4 || nr < 4); c++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00 && ng < 4) begin
                grants[ng] = bus.req_ready;
                gcyc[ng] = c;
                ng++;
            end
            if (bus.rsp_valid && nr < 4) begin
                ids[nr] = {1'b0, bus.rsp_id};
                datas[nr] = bus.rsp_data;
                nr++;
            end
        end
        bus.req_valid = 2'b00;
        chk("rr_count", 64'(ng * 10 + nr), 64'd44);
        for (int i = 0; i < 4 && i < ng && i < nr; i++) begin
            chk($sformatf("rr_grant%0d", i), 64'(grants[i]), (i % 2) ? 64'd2 : 64'd1);
            chk($sformatf("rr_id%0d", i), 64'(ids[i]), 64'(i % 2));
            chk($sformatf("rr_data%0d", i), datas[i], (i % 2) ? 64'd4 : 64'd2);
        end
        gap = (ng == 4) ? gcyc[1] - gcyc[0] : 0;
        chk("rr_period", 64'(gap), 64'd4);
        repeat (6) to_idle();
`ifdef FPU_ISSUE_CTRL_STICKY_FLAGS_EN
        flags_clr = 1'b1;
        to_idle();
        flags_clr = 1'b0;
        #1;
        chk("sticky_clr", 64'(flags_sticky), 64'd0);
        issue(0, 2'b00, 64'h1, 64'h1, 1'b0, 2'b00);
        wait_rsp(lat);
        chk("sticky_op1", 64'(flags_sticky), 64'h01);
        to_idle();
        issue(0, 2'b10, 64'h1, 64'h2, 1'b0, 2'b00);
        wait_rsp(lat);
        chk("sticky_op2", 64'(flags_sticky), 64'h05);
        to_idle();
        issue(0, 2'b00, 64'h1, 64'h1, 1'b0, 2'b00);
        to_idle();
        flags_clr = 1'b1;
        to_idle();
        flags_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_cap_valid", 64'(bus.rsp_valid), 64'd1);
        chk("sticky_clr_cap", 64'(flags_sticky), 64'd0);
        to_idle();
`endif
        chk("no_ready_when_busy", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
